// File: rtl/tx_protocol_pkg.sv
// Shared constants, header packing and CRC-8 step for the TX link framer.
// Optional CRC support is controlled by the TX_CRC_EN macro.
package tx_protocol_pkg;

  localparam logic [7:0]  K28_5        = 8'hBC;
  localparam logic [31:0] IDLE_WORD    = 32'h0000_00BC;
  localparam logic [3:0]  HDR_CHARISK  = 4'b0001;
  localparam logic [3:0]  DATA_CHARISK = 4'b0000;

  localparam int HDR_K_LSB    = 0;
  localparam int HDR_B1_LSB   = 8;
  localparam int HDR_BCID_LSB = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  charisk;
    logic        valid;
  } tx_out_t;

  function automatic logic [31:0] hdr_word(
    input logic [11:0] bcid,
    input logic [7:0]  byte1
  );
    logic [31:0] w;
    w = '0;
    w[HDR_K_LSB    +: 8]  = K28_5;
    w[HDR_B1_LSB   +: 8]  = byte1;
    w[HDR_BCID_LSB +: 12] = bcid;
    return w;
  endfunction

  // CRC-8, poly 0x07, MSB of the word first.
  function automatic logic [7:0] crc8_step(
    input logic [7:0]  crc,
    input logic [23:0] word
  );
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      fb = c[7] ^ word[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_protocol_wrapper_crc8.sv
// Per-frame CRC-8 accumulator; result holds the CRC of the last full frame.
// Only built when TX_CRC_EN is defined.
`ifdef TX_CRC_EN
module tx_crc8
  import tx_protocol_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        done_i,
  input  logic [23:0] word_i,
  output logic [7:0]  result_o
);

  logic [7:0] crc_q, crc_d;
  logic [7:0] res_q, res_d;
  logic [7:0] nxt;

  // Accumulate one word per enabled cycle; latch result on the last word.
  always_comb begin
    nxt   = crc8_step(crc_q, word_i);
    crc_d = crc_q;
    res_d = res_q;
    if (clr_i) begin
      crc_d = 8'hFF;
    end else if (en_i) begin
      crc_d = nxt;
      if (done_i) res_d = nxt;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 8'hFF;
      res_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule
`endif

// File: rtl/tx_protocol_wrapper.sv
// Frames 24-bit user words behind a K28.5/BCID header for the MGT TX path.
// Define TX_CRC_EN to carry the previous frame's CRC-8 in header byte 1.
module tx_protocol_wrapper
  import tx_protocol_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 24
) (
  input  logic        clk240_i,
  input  logic        rst_i,
  input  logic [23:0] tx_user_word_i,
  input  logic        bc0_i,
  input  logic [11:0] bcid_i,
  output logic        data_valid_o,
  output logic [31:0] txdata_o,
  output logic [3:0]  txcharisk_o
);

  localparam logic [7:0] LAST_SLOT = 8'(WORDS_PER_FRAME);

  logic [7:0] slot_q, slot_d;
  logic       locked_q, locked_d;
  tx_out_t    out_q, out_d;

  logic [7:0] eff_slot;
  logic       is_hdr;
  logic       is_data;
  logic       last;
  logic [7:0] hdr_b1;

`ifdef TX_CRC_EN
  logic       trunc;
  logic [7:0] frame_crc;

  assign trunc  = bc0_i & locked_q & (slot_q != 8'd0);
  assign hdr_b1 = trunc ? 8'h00 : frame_crc;

  tx_crc8 u_crc (
    .clk_i    (clk240_i),
    .rst_i    (rst_i),
    .clr_i    (is_hdr),
    .en_i     (is_data),
    .done_i   (last),
    .word_i   (tx_user_word_i),
    .result_o (frame_crc)
  );
`else
  assign hdr_b1 = 8'h00;
`endif

  // bc0 forces the current cycle to be a header slot.
  always_comb begin
    locked_d = locked_q | bc0_i;
    eff_slot = bc0_i ? 8'd0 : slot_q;
    is_hdr   = locked_d & (eff_slot == 8'd0);
    is_data  = locked_d & (eff_slot != 8'd0);
    last     = is_data & (eff_slot == LAST_SLOT);
    slot_d   = slot_q;
    if (locked_d) slot_d = last ? 8'd0 : eff_slot + 8'd1;

    out_d.data    = IDLE_WORD;
    out_d.charisk = HDR_CHARISK;
    out_d.valid   = 1'b0;
    unique case (1'b1)
      is_hdr: begin
        out_d.data = hdr_word(bcid_i, hdr_b1);
      end
      is_data: begin
        out_d.data    = {eff_slot, tx_user_word_i};
        out_d.charisk = DATA_CHARISK;
        out_d.valid   = 1'b1;
      end
      default: ;
    endcase
  end

  // Slot counter, lock flag and registered outputs.
  always_ff @(posedge clk240_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q   <= 8'd0;
      locked_q <= 1'b0;
      out_q    <= '{data: IDLE_WORD, charisk: HDR_CHARISK, valid: 1'b0};
    end else begin
      slot_q   <= slot_d;
      locked_q <= locked_d;
      out_q    <= out_d;
    end
  end

  assign txdata_o     = out_q.data;
  assign txcharisk_o  = out_q.charisk;
  assign data_valid_o = out_q.valid;

endmodule

// File: tb/tb_tx_protocol_wrapper.sv
// Scoreboard bench for tx_protocol_wrapper with a frame-level reference model.
// Build with TX_CRC_EN defined to check the CRC header byte.
module tb_tx_protocol_wrapper;

  localparam int WPF = 24;
`ifdef TX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] word;
  logic        bc0;
  logic [11:0] bcid;
  logic        dv;
  logic [31:0] txd;
  logic [3:0]  k;

  tx_protocol_wrapper #(.WORDS_PER_FRAME(WPF)) dut (
    .clk240_i       (clk),
    .rst_i          (rst),
    .tx_user_word_i (word),
    .bc0_i          (bc0),
    .bcid_i         (bcid),
    .data_valid_o   (dv),
    .txdata_o       (txd),
    .txcharisk_o    (k)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  bit          m_locked;
  int          m_slot;
  logic [23:0] fw[$];
  logic [7:0]  last_crc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] ad, input logic [3:0] ak,
                       input logic av,
                       input logic [31:0] ed, input logic [3:0] ek,
                       input logic ev);
    tests++;
    if (ad !== ed || ak !== ek || av !== ev) begin
      fails++;
      $display("FAIL %s @%0d: got %h/%b/%b expected %h/%b/%b",
               nm, cyc, ad, ak, av, ed, ek, ev);
    end
  endtask

  // Monitor: compare every output whose cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("sb", txd, k, dv, e.d, e.k, e.v);
    end
  end

  // Byte-wise table-free CRC-8 over a list of 24-bit words.
  function automatic logic [7:0] ref_crc(input logic [23:0] ws[$]);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'hFF;
    foreach (ws[n]) begin
      for (int j = 2; j >= 0; j--) begin
        b = ws[n][j*8 +: 8];
        c = c ^ b;
        repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_slot   = 0;
    fw.delete();
    last_crc = 8'h00;
  endtask

  task automatic push_idle();
    exp_t e;
    e.due = cyc + 1;
    e.d   = 32'h0000_00BC;
    e.k   = 4'b0001;
    e.v   = 1'b0;
    q.push_back(e);
  endtask

  task automatic step(input logic [23:0] w, input bit b,
                      input logic [11:0] id);
    exp_t       e;
    bit         trunc;
    logic [7:0] b1;
    @(negedge clk);
    word  = w;
    bc0   = b;
    bcid  = id;
    trunc = 1'b0;
    if (b) begin
      trunc    = m_locked && m_slot != 0;
      m_locked = 1'b1;
      m_slot   = 0;
    end
    e.due = cyc + 1;
    if (!m_locked) begin
      e.d = 32'h0000_00BC; e.k = 4'b0001; e.v = 1'b0;
    end else if (m_slot == 0) begin
      b1  = (CRC_EN && !trunc) ? last_crc : 8'h00;
      e.d = {4'h0, id, b1, 8'hBC}; e.k = 4'b0001; e.v = 1'b0;
      fw.delete();
    end else begin
      e.d = {m_slot[7:0], w}; e.k = 4'b0000; e.v = 1'b1;
      fw.push_back(w);
      if (m_slot == WPF) begin
        last_crc = ref_crc(fw);
        fw.delete();
      end
    end
    if (m_locked) m_slot = (m_slot == WPF) ? 0 : m_slot + 1;
    q.push_back(e);
  endtask

  task automatic rnd_step();
    step(24'($urandom), 1'b0, 12'($urandom));
  endtask

  task automatic run_to_slot(input int n);
    for (int i = 0; i < 200 && m_slot != n; i++) rnd_step();
    tests++;
    if (m_slot != n) begin
      fails++;
      $display("FAIL run_to_slot: got %0d expected %0d", m_slot, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    bc0 = 1'b0;
    #1 check("rst_async", txd, k, dv, 32'h0000_00BC, 4'b0001, 1'b0);
    q.delete();
    model_reset();
    @(negedge clk);
    check("rst_hold", txd, k, dv, 32'h0000_00BC, 4'b0001, 1'b0);
    rst = 1'b0;
    push_idle();
  endtask

  function automatic logic [23:0] bcdw(input int i);
    return 24'hDE0000 | 24'((i / 10) << 4) | 24'(i % 10);
  endfunction

  initial begin
    rst  = 1'b1;
    bc0  = 1'b0;
    word = '0;
    bcid = '0;
    model_reset();
    #3 check("reset", txd, k, dv, 32'h0000_00BC, 4'b0001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_idle();

    repeat (10) rnd_step();

    step(24'($urandom), 1'b1, 12'd0);
    for (int i = 1; i <= WPF; i++) step(bcdw(i), 1'b0, 12'($urandom));

    step(bcdw(1), 1'b0, 12'd4);
    for (int i = 2; i <= WPF; i++) step(bcdw(i), 1'b0, 12'($urandom));
    rnd_step();

    step(24'($urandom), 1'b1, 12'd7);
    run_to_slot(0);
    run_to_slot(10);
    step(24'($urandom), 1'b1, 12'd9);
    run_to_slot(0);
    run_to_slot(1);
    run_to_slot(0);

    run_to_slot(5);
    do_reset();
    repeat (5) rnd_step();
    step(24'($urandom), 1'b1, 12'($urandom));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(24'($urandom), $urandom_range(0, 39) == 0,
                12'($urandom));
    end
    run_to_slot(0);
    rnd_step();

    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
